// File: rtl/dlsc_rvh_checker.sv
// dlsc_rvh_checker: consumer-end checker for ready/valid/hold streams.
// Applies LFSR-driven backpressure, checks accepted beats against an
// incrementing reference (resynchronising after each beat) and flags
// violations of the source-side hold rule.
module dlsc_rvh_checker #(
    parameter int              DATA        = 32,
    parameter logic [DATA-1:0] INIT        = {DATA{1'b0}},
    parameter logic [15:0]     SEED        = 16'hACE1,
    parameter int              THROTTLE    = 0,
    parameter bit              STOP_ON_ERR = 1'b0
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            enable,
    input  logic            clear,
    output logic            in_ready,
    input  logic            in_valid,
    input  logic [DATA-1:0] in_data,
    output logic [31:0]     beat_count,
    output logic [15:0]     err_count,
    output logic            err_first_valid,
    output logic [DATA-1:0] err_first_exp,
    output logic [DATA-1:0] err_first_act,
    output logic            proto_err,
    output logic            halted
);

    // An all-zero seed would lock the LFSR, so substitute 1.
    localparam logic [15:0] SEED_EFF = (SEED == 16'h0000) ? 16'h0001 : SEED;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_HALT = 2'd2
    } state_t;

    state_t          state_reg, state_next;
    logic [15:0]     lfsr_reg, lfsr_next;
    logic            ready_reg, ready_next;
    logic [DATA-1:0] exp_reg, exp_next;
    logic [31:0]     beat_reg, beat_next;
    logic [15:0]     err_reg, err_next;
    logic            efv_reg, efv_next;
    logic [DATA-1:0] efe_reg, efe_next;
    logic [DATA-1:0] efa_reg, efa_next;
    logic            proto_reg, proto_next;
    logic            stall_reg;
    logic [DATA-1:0] stall_data_reg;

    logic accept;
    logic mismatch;
    logic hold_viol;
    logic lfsr_pass;

    // Galois step for x^16+x^14+x^13+x^11+1 (right-shifting form).
    function automatic logic [15:0] lfsr_step(input logic [15:0] s);
        return s[0] ? ((s >> 1) ^ 16'hB400) : (s >> 1);
    endfunction

    // Throttle compare; the zero case is a constant pass so no
    // always-true unsigned comparison is built.
    generate
        if (THROTTLE == 0) begin : g_no_throttle
            assign lfsr_pass = 1'b1;
        end else begin : g_throttle
            assign lfsr_pass = (lfsr_reg[7:0] >= 8'(THROTTLE));
        end
    endgenerate

    // A beat taken during clear is discarded entirely.
    assign accept    = in_valid && ready_reg && !clear;
    assign mismatch  = accept && (in_data != exp_reg);
    // Source stalled last cycle: it must still be valid with the same data.
    assign hold_viol = stall_reg && (!in_valid || (in_data != stall_data_reg));

    // Next-state logic; clear overrides every transition including HALT.
    always_comb begin
        state_next = state_reg;
        case (state_reg)
            ST_IDLE: if (enable) state_next = ST_RUN;
            ST_RUN: begin
                if (STOP_ON_ERR && mismatch) state_next = ST_HALT;
                else if (!enable)            state_next = ST_IDLE;
            end
            ST_HALT: state_next = ST_HALT;
            default: state_next = ST_IDLE;
        endcase
        if (clear) state_next = enable ? ST_RUN : ST_IDLE;
    end

    // Datapath next values: LFSR, ready, counters, captures, sticky flag.
    always_comb begin
        lfsr_next  = lfsr_reg;
        ready_next = 1'b0;
        exp_next   = exp_reg;
        beat_next  = beat_reg;
        err_next   = err_reg;
        efv_next   = efv_reg;
        efe_next   = efe_reg;
        efa_next   = efa_reg;
        proto_next = proto_reg | hold_viol;

        if (state_reg == ST_RUN) lfsr_next = lfsr_step(lfsr_reg);
        ready_next = (state_next == ST_RUN) && lfsr_pass;

        if (accept) begin
            beat_next = beat_reg + 32'd1;
            exp_next  = in_data + DATA'(1);
            if (mismatch) begin
                if (err_reg != 16'hFFFF) err_next = err_reg + 16'd1;
                if (!efv_reg) begin
                    efv_next = 1'b1;
                    efe_next = exp_reg;
                    efa_next = in_data;
                end
            end
        end

        if (clear) begin
            lfsr_next  = SEED_EFF;
            ready_next = 1'b0;
            exp_next   = INIT;
            beat_next  = 32'd0;
            err_next   = 16'd0;
            efv_next   = 1'b0;
            efe_next   = {DATA{1'b0}};
            efa_next   = {DATA{1'b0}};
            proto_next = 1'b0;
        end
    end

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state_reg <= ST_IDLE;
        else        state_reg <= state_next;
    end

    // Datapath registers and hold tracker.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            lfsr_reg       <= SEED_EFF;
            ready_reg      <= 1'b0;
            exp_reg        <= INIT;
            beat_reg       <= 32'd0;
            err_reg        <= 16'd0;
            efv_reg        <= 1'b0;
            efe_reg        <= {DATA{1'b0}};
            efa_reg        <= {DATA{1'b0}};
            proto_reg      <= 1'b0;
            stall_reg      <= 1'b0;
            stall_data_reg <= {DATA{1'b0}};
        end else begin
            lfsr_reg       <= lfsr_next;
            ready_reg      <= ready_next;
            exp_reg        <= exp_next;
            beat_reg       <= beat_next;
            err_reg        <= err_next;
            efv_reg        <= efv_next;
            efe_reg        <= efe_next;
            efa_reg        <= efa_next;
            proto_reg      <= proto_next;
            stall_reg      <= in_valid && !ready_reg;
            stall_data_reg <= in_data;
        end
    end

    assign in_ready        = ready_reg;
    assign beat_count      = beat_reg;
    assign err_count       = err_reg;
    assign err_first_valid = efv_reg;
    assign err_first_exp   = efe_reg;
    assign err_first_act   = efa_reg;
    assign proto_err       = proto_reg;
    assign halted          = (state_reg == ST_HALT);

endmodule

// File: tb/tb_dlsc_rvh_checker.sv
// Testbench for dlsc_rvh_checker: a per-cycle vector table on an
// unthrottled instance, then multi-cycle sequences on both instances.
module tb_dlsc_rvh_checker;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        en   [2];
    logic        clr  [2];
    logic        vld  [2];
    logic [31:0] dat  [2];
    logic        rdy  [2];
    logic [31:0] beat [2];
    logic [15:0] errc [2];
    logic        efv  [2];
    logic [31:0] eexp [2];
    logic [31:0] eact [2];
    logic        proto[2];
    logic        halt [2];

    int checks = 0;
    int failures = 0;

    always #5 clk = ~clk;

    // Instance 0: no throttle, run-through on error, INIT = 0.
    dlsc_rvh_checker #(.DATA(32), .INIT(32'd0), .SEED(16'hACE1),
                       .THROTTLE(0), .STOP_ON_ERR(1'b0)) dut0 (
        .clk(clk), .rst_n(rst_n), .enable(en[0]), .clear(clr[0]),
        .in_ready(rdy[0]), .in_valid(vld[0]), .in_data(dat[0]),
        .beat_count(beat[0]), .err_count(errc[0]),
        .err_first_valid(efv[0]), .err_first_exp(eexp[0]),
        .err_first_act(eact[0]), .proto_err(proto[0]), .halted(halt[0]));

    // Instance 1: ~25% ready, stop on error, INIT = 100.
    dlsc_rvh_checker #(.DATA(32), .INIT(32'd100), .SEED(16'hACE1),
                       .THROTTLE(192), .STOP_ON_ERR(1'b1)) dut1 (
        .clk(clk), .rst_n(rst_n), .enable(en[1]), .clear(clr[1]),
        .in_ready(rdy[1]), .in_valid(vld[1]), .in_data(dat[1]),
        .beat_count(beat[1]), .err_count(errc[1]),
        .err_first_valid(efv[1]), .err_first_exp(eexp[1]),
        .err_first_act(eact[1]), .proto_err(proto[1]), .halted(halt[1]));

    typedef struct {
        logic        en, clr, v;
        logic [31:0] d;
        logic        r;
        logic [31:0] beat;
        logic [15:0] err;
        logic        fv;
        logic        proto;
    } vec_t;

    vec_t tbl[16];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end else begin
            $display("ok   %s: %0d", name, act);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Source model: presents each value and holds it until accepted.
    task automatic stream(input int idx, input logic [31:0] start, input int n, output int cyc);
        cyc = 0;
        for (int k = 0; k < n; k++) begin
            bit done;
            int guard;
            done  = 1'b0;
            guard = 0;
            vld[idx] = 1'b1;
            dat[idx] = start + 32'(k);
            while (!done) begin
                done = rdy[idx];
                cyc++;
                guard++;
                step();
                if (!done && guard > 400) begin
                    checks++;
                    failures++;
                    $display("FAIL stream_timeout: inst %0d stuck at value %0d, expected accept within 400 cycles",
                             idx, dat[idx]);
                    vld[idx] = 1'b0;
                    return;
                end
            end
        end
        vld[idx] = 1'b0;
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached, expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        int cyc;
        int rcount;

        for (int i = 0; i < 2; i++) begin
            en[i] = 1'b0; clr[i] = 1'b0; vld[i] = 1'b0; dat[i] = 32'd0;
        end

        //            en  clr v   d      r   beat   err    fv  proto
        tbl[0]  = '{1'b0,1'b0,1'b0,32'd0,1'b0,32'd0,16'd0,1'b0,1'b0};
        tbl[1]  = '{1'b1,1'b0,1'b1,32'd0,1'b1,32'd0,16'd0,1'b0,1'b0};
        tbl[2]  = '{1'b1,1'b0,1'b1,32'd0,1'b1,32'd1,16'd0,1'b0,1'b0};
        tbl[3]  = '{1'b1,1'b0,1'b1,32'd1,1'b1,32'd2,16'd0,1'b0,1'b0};
        tbl[4]  = '{1'b1,1'b0,1'b1,32'd3,1'b1,32'd3,16'd1,1'b1,1'b0};
        tbl[5]  = '{1'b1,1'b0,1'b1,32'd4,1'b1,32'd4,16'd1,1'b1,1'b0};
        tbl[6]  = '{1'b1,1'b0,1'b0,32'd0,1'b1,32'd4,16'd1,1'b1,1'b0};
        tbl[7]  = '{1'b1,1'b1,1'b1,32'd0,1'b0,32'd0,16'd0,1'b0,1'b0};
        tbl[8]  = '{1'b1,1'b0,1'b1,32'd0,1'b1,32'd0,16'd0,1'b0,1'b0};
        tbl[9]  = '{1'b1,1'b0,1'b1,32'd0,1'b1,32'd1,16'd0,1'b0,1'b0};
        tbl[10] = '{1'b1,1'b0,1'b1,32'd1,1'b1,32'd2,16'd0,1'b0,1'b0};
        tbl[11] = '{1'b0,1'b0,1'b1,32'd2,1'b0,32'd3,16'd0,1'b0,1'b0};
        tbl[12] = '{1'b0,1'b0,1'b1,32'd3,1'b0,32'd3,16'd0,1'b0,1'b0};
        tbl[13] = '{1'b0,1'b0,1'b0,32'd0,1'b0,32'd3,16'd0,1'b0,1'b1};
        tbl[14] = '{1'b0,1'b0,1'b0,32'd0,1'b0,32'd3,16'd0,1'b0,1'b1};
        tbl[15] = '{1'b0,1'b1,1'b0,32'd0,1'b0,32'd0,16'd0,1'b0,1'b0};

        repeat (3) @(posedge clk);
        #1;
        rst_n = 1'b1;

        // Per-cycle vectors: outputs checked just after the edge that consumed the inputs.
        for (int i = 0; i < 16; i++) begin
            en[0] = tbl[i].en; clr[0] = tbl[i].clr; vld[0] = tbl[i].v; dat[0] = tbl[i].d;
            step();
            chk($sformatf("row%0d_ready", i), rdy[0], tbl[i].r);
            chk($sformatf("row%0d_beat", i), beat[0], tbl[i].beat);
            chk($sformatf("row%0d_err", i), errc[0], tbl[i].err);
            chk($sformatf("row%0d_efv", i), efv[0], tbl[i].fv);
            chk($sformatf("row%0d_proto", i), proto[0], tbl[i].proto);
        end
        clr[0] = 1'b0; vld[0] = 1'b0;

        // 1000 back-to-back beats with no throttle.
        en[0] = 1'b1;
        step();
        stream(0, 32'd0, 1000, cyc);
        chk("b2b_cycles", cyc, 1000);
        chk("b2b_beat", beat[0], 1000);
        chk("b2b_err", errc[0], 0);
        chk("b2b_proto", proto[0], 0);

        // Dropped beat 10: one error, resync afterwards.
        clr[0] = 1'b1; step(); clr[0] = 1'b0;
        stream(0, 32'd0, 10, cyc);
        stream(0, 32'd11, 10, cyc);
        chk("skip_beat", beat[0], 20);
        chk("skip_err", errc[0], 1);
        chk("skip_efv", efv[0], 1);
        chk("skip_exp", eexp[0], 10);
        chk("skip_act", eact[0], 11);

        // Data changes during a stall (checker idle, ready low).
        en[0] = 1'b0; clr[0] = 1'b1; step(); clr[0] = 1'b0; step();
        vld[0] = 1'b1; dat[0] = 32'd5; step();
        chk("hold_pre_proto", proto[0], 0);
        dat[0] = 32'd6; step();
        chk("hold_proto_set", proto[0], 1);
        vld[0] = 1'b0; step(); step();
        chk("hold_proto_sticky", proto[0], 1);
        clr[0] = 1'b1; step(); clr[0] = 1'b0;
        chk("hold_proto_clear", proto[0], 0);

        // Throttled stream of 500 beats with the source holding while stalled.
        en[1] = 1'b1; clr[1] = 1'b1; step(); clr[1] = 1'b0;
        stream(1, 32'd100, 500, cyc);
        $display("info throttle: 500 beats took %0d cycles", cyc);
        chk("thr_beat", beat[1], 500);
        chk("thr_err", errc[1], 0);
        chk("thr_proto", proto[1], 0);
        chk("thr_ready_share_in_range", (cyc >= 1500 && cyc <= 2800), 1);

        // Stop on error: 100,101,107 halts the checker.
        clr[1] = 1'b1; step(); clr[1] = 1'b0;
        stream(1, 32'd100, 2, cyc);
        stream(1, 32'd107, 1, cyc);
        chk("stop_halted", halt[1], 1);
        chk("stop_ready", rdy[1], 0);
        chk("stop_err", errc[1], 1);
        chk("stop_beat", beat[1], 3);
        chk("stop_exp", eexp[1], 102);
        chk("stop_act", eact[1], 107);
        rcount = 0;
        for (int i = 0; i < 6; i++) begin
            if (rdy[1]) rcount++;
            step();
        end
        chk("stop_ready_cycles", rcount, 0);
        chk("stop_beat_hold", beat[1], 3);
        clr[1] = 1'b1; step(); clr[1] = 1'b0;
        chk("stop_clear_halted", halt[1], 0);
        chk("stop_clear_beat", beat[1], 0);
        chk("stop_clear_err", errc[1], 0);
        chk("stop_clear_ready", rdy[1], 0);
        stream(1, 32'd100, 1, cyc);
        chk("stop_resume_beat", beat[1], 1);
        chk("stop_resume_err", errc[1], 0);

        // Asynchronous reset in the middle of a stream.
        en[0] = 1'b1; step();
        stream(0, 32'd0, 37, cyc);
        chk("rst_pre_beat", beat[0], 37);
        vld[0] = 1'b1; dat[0] = 32'd37;
        #3;
        rst_n = 1'b0;
        #1;
        chk("rst_ready", rdy[0], 0);
        chk("rst_beat", beat[0], 0);
        chk("rst_err", errc[0], 0);
        chk("rst_efv", efv[0], 0);
        chk("rst_exp", eexp[0], 0);
        chk("rst_act", eact[0], 0);
        chk("rst_proto", proto[0], 0);
        chk("rst_halted", halt[0], 0);
        step(); step();
        vld[0] = 1'b0;
        rst_n = 1'b1;
        stream(0, 32'd0, 3, cyc);
        chk("rst_after_beat", beat[0], 3);
        chk("rst_after_err", errc[0], 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/dlsc_rvh_checker.md
# dlsc_rvh_checker

Single-clock consumer-end checker for ready/valid/hold (rvh) streams. It sinks the output side of any rvh block, such as a domain crossing, FIFO, or pipeline, and applies pseudo-random backpressure on `in_ready`. It checks every accepted beat against an incrementing reference sequence and flags rvh hold-rule violations. It is the receiving counterpart to a stream source in cross-domain and pipeline test harnesses.

## Interface
Parameters:
- `DATA`, 32: data width (1..64).
- `INIT`, `{DATA{1'b0}}`: first expected data value.
- `SEED`, 16'hACE1: backpressure LFSR seed. A value of 0 is replaced by 16'h0001.
- `THROTTLE`, 0: backpressure level (0..255). 0 means `in_ready` is held high whenever running.
- `STOP_ON_ERR`, 0: 1 halts the checker on the first data mismatch.

Ports:
- `clk`  in  1  single clock. All logic is on the rising edge.
- `rst_n`  in  1  asynchronous, active-low reset.
- `enable`  in  1  run the checker. When low, `in_ready` is 0.
- `clear`  in  1  synchronous clear of counters, captures and the expected value.
- `in_ready`  out  1  registered ready to the upstream source.
- `in_valid`  in  1  upstream valid.
- `in_data`  in  DATA  upstream data.
- `beat_count`  out  32  accepted beats, wrapping.
- `err_count`  out  16  data mismatches, saturating at 16'hFFFF.
- `err_first_valid`  out  1  a first-error capture is held.
- `err_first_exp`  out  DATA  expected value at the first mismatch.
- `err_first_act`  out  DATA  received value at the first mismatch.
- `proto_err`  out  1  sticky flag for an rvh hold-rule violation.
- `halted`  out  1  the checker is in HALT.

## Operation
- Three states: IDLE, RUN, HALT. Reset state is IDLE.
- IDLE → RUN when `enable`=1. RUN → IDLE when `enable`=0. RUN → HALT on a mismatch when `STOP_ON_ERR`=1.
- HALT is left only by `clear`, which goes to RUN if `enable`=1, otherwise to IDLE, or by reset.
- Backpressure LFSR:
  - 16-bit Galois, polynomial x^16+x^14+x^13+x^11+1.
  - Advances every cycle the checker is in RUN.
  - Next-cycle `in_ready` = RUN && (lfsr[7:0] >= `THROTTLE`). In IDLE and HALT, `in_ready` = 0.
- Accept occurs when `in_valid && in_ready` at a rising edge.
- On each accept:
  - `beat_count` += 1, modulo 2^32.
  - If `in_data` != exp: `err_count` += 1 (saturating). If `err_first_valid`=0, latch exp and `in_data` into the capture registers and set `err_first_valid`.
  - exp <= `in_data` + 1, modulo 2^DATA. The checker resynchronises so one dropped beat produces exactly one error.
- Hold check:
  - Applies when the previous cycle had `in_valid`=1 and `in_ready`=0.
  - The current cycle must then have `in_valid`=1 and `in_data` equal to the previous data. Otherwise set `proto_err`.
  - The check runs in every state.
- `clear`:
  - Zeroes `beat_count`, `err_count`, `err_first_*` and `proto_err`, sets exp <= `INIT`, and reloads the LFSR with `SEED`.
  - Forces `in_ready` to 0 on the next cycle.
  - A beat accepted in the same cycle as `clear` is discarded: not counted and not checked.
  - `clear` has priority over every update.

## Timing
- Reset (`rst_n`=0, asynchronous):
  - Outputs: `in_ready`=0, all counters 0, `err_first_*`=0, `proto_err`=0, `halted`=0.
  - Internal: exp=`INIT`, LFSR=`SEED`, state IDLE.
  - Reset mid-stream drops any in-flight beat. The hold tracker is cleared.
- `in_ready` is a register output with no combinational path from `in_valid`/`in_data`.
- First `in_ready`=1 appears 1 cycle after `enable` rises. With `THROTTLE`=0, `in_ready` stays 1 every cycle while in RUN.
- `beat_count`, `err_count`, captures, `proto_err` and `halted` update 1 cycle after the accept or violation edge.
- With `STOP_ON_ERR`=1, `in_ready` falls on the cycle after the mismatching accept. No further beats are accepted.
- Dropping `enable` while a beat is pending never violates rvh. Only the source must hold; the checker may withdraw ready freely.

## Test plan
- `THROTTLE`=0, `INIT`=0; source sends 0..999 back-to-back → `in_ready` is high throughout, `beat_count`=1000, `err_count`=0, `proto_err`=0.
- `THROTTLE`=192; source sends 0..499 and holds valid/data while stalled → `in_ready` is high in roughly 25% of RUN cycles, `beat_count`=500, `err_count`=0.
- Source sends 0..9, skips 10, then sends 11..20 → `err_count`=1, `err_first_exp`=10, `err_first_act`=11, `beat_count`=20.
- Source changes data from 5 to 6 during a stall (valid=1, ready=0) → `proto_err`=1 on the next cycle, stays set until `clear`.
- `STOP_ON_ERR`=1; source sends 0,1,7 → `halted`=1, `in_ready`=0 from the cycle after beat 7. `clear` with `enable`=1 returns to RUN and `beat_count`=0.
- Assert `rst_n`=0 mid-stream after 37 beats → all outputs are 0 immediately. After release with `enable`=1, the first expected value is `INIT`.
